dram_image_loader: RTL

- Writer-side counterpart to the data-RAM readout path: accepts a raw 8-bit pixel byte stream over a valid/ready handshake and writes it sequentially into data RAM, starting at address 0.
- Sits between the host byte source (UART/JTAG bridge) and the data-RAM write port.
- Signals `load_done` when a full image has been written so the processor can be powered on and start downsampling.

---
 rtl/dram_image_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dram_image_loader.sv
// dram_image_loader: accepts a pixel byte stream over valid/ready and writes it
// sequentially into data RAM from address 0, flagging load_done when a full
// image of IMG_SIZE bytes has been written.
// Optional build macro LOADER_CHECKSUM_EN adds a 16-bit running byte checksum.
module dram_image_loader #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_SIZE   = 262144
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  dram_we,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  output logic                  busy,
  output logic                  load_done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  // One extra count bit so a full 2^ADDR_WIDTH image is representable.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(IMG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           count, count_nxt;
  logic                    in_ready_nxt, busy_nxt, load_done_nxt, we_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_nxt;
  logic                    accept;

  // in_ready is only ever high in LOAD, so acceptance implies LOAD.
  assign accept = in_valid && in_ready;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_nxt;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt     = state;
    count_nxt     = count;
    in_ready_nxt  = in_ready;
    busy_nxt      = busy;
    load_done_nxt = load_done;
    we_nxt        = 1'b0;
    addr_nxt      = dram_addr;
    wdata_nxt     = dram_wdata;
`ifdef LOADER_CHECKSUM_EN
    checksum_nxt  = checksum;
`endif

    // An accepted byte is written one cycle later, even if abort arrives with it.
    if (accept) begin
      we_nxt    = 1'b1;
      addr_nxt  = count[ADDR_WIDTH-1:0];
      wdata_nxt = in_data;
      count_nxt = count + CW'(1);
`ifdef LOADER_CHECKSUM_EN
      checksum_nxt = checksum + 16'(in_data);
`endif
    end

    case (state)
      IDLE, DONE: begin
        // start (re)begins a load; abort is meaningless here.
        if (start) begin
          state_nxt     = LOAD;
          count_nxt     = '0;
          in_ready_nxt  = 1'b1;
          busy_nxt      = 1'b1;
          load_done_nxt = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          checksum_nxt  = '0;
`endif
        end
      end
      LOAD: begin
        // abort beats both start and completion; start alone is ignored.
        if (abort) begin
          state_nxt    = IDLE;
          in_ready_nxt = 1'b0;
          busy_nxt     = 1'b0;
        end else if (accept && (count == LAST_COUNT)) begin
          state_nxt     = DONE;
          in_ready_nxt  = 1'b0;
          busy_nxt      = 1'b0;
          load_done_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        in_ready_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      count      <= count_nxt;
      in_ready   <= in_ready_nxt;
      busy       <= busy_nxt;
      load_done  <= load_done_nxt;
      dram_we    <= we_nxt;
      dram_addr  <= addr_nxt;
      dram_wdata <= wdata_nxt;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= checksum_nxt;
`endif
    end
  end

endmodule
